// File: rtl/grey_scan.sv
// Time-multiplexed 7-segment scanner for the 12-digit grey-coded decimal counter.
// Takes one snapshot per frame, then shows digits 11..0 with leading-zero blanking and error flagging.
module grey_scan #(
   parameter int unsigned DWELL = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [59:0] i_digits,
   input  logic        i_hold,
   output logic [6:0]  o_seg,
   output logic [3:0]  o_dig,
   output logic        o_frame,
   output logic        o_err
);

   // state | meaning
   // SNAP  | one cycle: capture digits into shadow (unless held), rewind scan
   // SHOW  | step through digits 11..0, each held DWELL cycles
   typedef enum logic {SNAP, SHOW} state_t;

   localparam logic [15:0] CNT_LAST  = 16'(DWELL - 1);
   localparam logic [4:0]  ZERO_CODE = 5'b10001;
   localparam logic [6:0]  SEG_ERR   = 7'h79;

   state_t      state_q;
   logic [59:0] shadow_q;
   logic [3:0]  idx_q;
   logic [15:0] cnt_q;
   logic        blank_q;
   logic [6:0]  seg_q;
   logic [3:0]  dig_q;
   logic        frame_q;
   logic        err_q;

   logic [4:0]  code_d;
   logic [6:0]  seg_dec_d;
   logic        valid_d;

   always_comb begin
      code_d = '0;
      for (int i = 0; i < 12; i++) begin
         if (idx_q == 4'(i)) code_d = shadow_q[i*5 +: 5];
      end
   end

   always_comb begin
      valid_d   = 1'b1;
      seg_dec_d = SEG_ERR;
      case (code_d)
         5'b10001: seg_dec_d = 7'h3F;
         5'b00001: seg_dec_d = 7'h06;
         5'b00011: seg_dec_d = 7'h5B;
         5'b00010: seg_dec_d = 7'h4F;
         5'b00110: seg_dec_d = 7'h66;
         5'b00100: seg_dec_d = 7'h6D;
         5'b01100: seg_dec_d = 7'h7D;
         5'b01000: seg_dec_d = 7'h07;
         5'b11000: seg_dec_d = 7'h7F;
         5'b10000: seg_dec_d = 7'h6F;
         default:  valid_d   = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= SNAP;
         shadow_q <= {12{ZERO_CODE}};
         idx_q    <= 4'd11;
         cnt_q    <= '0;
         blank_q  <= 1'b1;
         seg_q    <= 7'h00;
         dig_q    <= 4'hF;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         frame_q <= 1'b0;
         case (state_q)
            SNAP: begin
               if (!i_hold) shadow_q <= i_digits;
               blank_q <= 1'b1;
               idx_q   <= 4'd11;
               cnt_q   <= '0;
               state_q <= SHOW;
            end
            SHOW: begin
               if (cnt_q == '0) begin
                  dig_q   <= idx_q;
                  frame_q <= (idx_q == 4'd11);
                  if (!valid_d) begin
                     seg_q   <= SEG_ERR;
                     err_q   <= 1'b1;
                     blank_q <= 1'b0;
                  end else if (blank_q && code_d == ZERO_CODE && idx_q != 4'd0) begin
                     seg_q <= 7'h00;
                  end else begin
                     seg_q   <= seg_dec_d;
                     blank_q <= 1'b0;
                  end
               end
               // With DWELL=1 the load and the advance happen on the same edge.
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (idx_q == 4'd0) state_q <= SNAP;
                  else               idx_q   <= idx_q - 4'd1;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            default: state_q <= SNAP;
         endcase
      end
   end

   assign o_seg   = seg_q;
   assign o_dig   = dig_q;
   assign o_frame = frame_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_grey_scan.sv
// Scoreboard bench for grey_scan: a reference model pushes expected (digit, segment) slots
// per frame; the frame collector pops and compares them as the scanner presents each digit.
module tb_grey_scan;

   localparam int DWELL = 2;
   localparam int FRAME = 1 + 12 * DWELL;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [59:0] i_digits = '0;
   logic        i_hold = 1'b0;
   logic [6:0]  o_seg;
   logic [3:0]  o_dig;
   logic        o_frame;
   logic        o_err;

   typedef struct packed {
      logic [3:0] dig;
      logic [6:0] seg;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   grey_scan #(.DWELL(DWELL)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_digits (i_digits),
      .i_hold   (i_hold),
      .o_seg    (o_seg),
      .o_dig    (o_dig),
      .o_frame  (o_frame),
      .o_err    (o_err)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [4:0] enc(input logic [3:0] d);
      case (d)
         4'd0: return 5'b10001;
         4'd1: return 5'b00001;
         4'd2: return 5'b00011;
         4'd3: return 5'b00010;
         4'd4: return 5'b00110;
         4'd5: return 5'b00100;
         4'd6: return 5'b01100;
         4'd7: return 5'b01000;
         4'd8: return 5'b11000;
         4'd9: return 5'b10000;
         default: return 5'b11111;
      endcase
   endfunction

   function automatic logic [59:0] pack(input logic [47:0] bcd);
      logic [59:0] r;
      r = '0;
      for (int i = 0; i < 12; i++) r[i*5 +: 5] = enc(bcd[i*4 +: 4]);
      return r;
   endfunction

   // {valid, seg}
   function automatic logic [7:0] ref_dec(input logic [4:0] code);
      case (code)
         5'b10001: return {1'b1, 7'h3F};
         5'b00001: return {1'b1, 7'h06};
         5'b00011: return {1'b1, 7'h5B};
         5'b00010: return {1'b1, 7'h4F};
         5'b00110: return {1'b1, 7'h66};
         5'b00100: return {1'b1, 7'h6D};
         5'b01100: return {1'b1, 7'h7D};
         5'b01000: return {1'b1, 7'h07};
         5'b11000: return {1'b1, 7'h7F};
         5'b10000: return {1'b1, 7'h6F};
         default:  return {1'b0, 7'h79};
      endcase
   endfunction

   task automatic push_frame(input logic [59:0] d);
      logic       blank;
      logic [4:0] code;
      logic [7:0] r;
      exp_t       e;
      blank = 1'b1;
      for (int idx = 11; idx >= 0; idx--) begin
         code  = d[idx*5 +: 5];
         r     = ref_dec(code);
         e.dig = 4'(idx);
         if (!r[7]) begin
            e.seg = 7'h79;
            blank = 1'b0;
         end else if (blank && code == 5'b10001 && idx != 0) begin
            e.seg = 7'h00;
         end else begin
            e.seg = r[6:0];
            blank = 1'b0;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic collect_frame(input logic exp_err, input bit do_mid, input logic [59:0] mid_val);
      int   n;
      exp_t e;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_frame && n < 4 * FRAME);
      total_cnt++;
      if (!o_frame) begin
         $display("FAIL frame_start: o_frame never rose within %0d cycles (got 0, need 1)", 4 * FRAME);
         return;
      end
      pass_cnt++;
      for (int k = 0; k < 12; k++) begin
         if (k > 0) repeat (DWELL) @(negedge i_clk);
         if (do_mid && k == 5) i_digits = mid_val;
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL slot%0d: scoreboard empty, got dig=%h seg=%h", k, o_dig, o_seg);
            continue;
         end
         e = exp_q.pop_front();
         if (o_dig !== e.dig || o_seg !== e.seg)
            $display("FAIL slot%0d: got dig=%h seg=%h, need dig=%h seg=%h", k, o_dig, o_seg, e.dig, e.seg);
         else
            pass_cnt++;
         if (k == 1) begin
            total_cnt++;
            if (o_frame !== 1'b0) $display("FAIL frame_width: o_frame=%b at second slot, need 0", o_frame);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if (o_err !== exp_err) $display("FAIL err_end: o_err=%b, need %b", o_err, exp_err);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      #3 i_rst = 1'b1;
      #2;
      total_cnt++;
      if (o_seg !== 7'h00 || o_dig !== 4'hF || o_frame !== 1'b0 || o_err !== 1'b0)
         $display("FAIL reset_vals: got seg=%h dig=%h frame=%b err=%b, need 00 F 0 0", o_seg, o_dig, o_frame, o_err);
      else
         pass_cnt++;
      i_digits = pack(48'h000000000000);
      repeat (3) @(negedge i_clk);
      i_rst = 1'b0;
      push_frame(i_digits);
      collect_frame(1'b0, 1'b0, '0);
   endtask

   task automatic test_frame_period;
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_frame && n < 4 * FRAME);
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_frame && n < 4 * FRAME);
      total_cnt++;
      if (n !== FRAME) $display("FAIL frame_period: got %0d cycles, need %0d", n, FRAME);
      else pass_cnt++;
   endtask

   task automatic test_counting;
      i_digits = pack(48'h001234567890);
      push_frame(i_digits);
      collect_frame(1'b0, 1'b0, '0);
   endtask

   task automatic test_embedded_zeros;
      i_digits = pack(48'h000000100100);
      push_frame(i_digits);
      collect_frame(1'b0, 1'b0, '0);
   endtask

   task automatic test_invalid;
      logic [59:0] d;
      d = pack(48'h000000000000);
      d[9:5] = 5'b11111;
      i_digits = d;
      push_frame(d);
      collect_frame(1'b1, 1'b0, '0);
      i_digits = pack(48'h000000000042);
      push_frame(i_digits);
      collect_frame(1'b1, 1'b0, '0);
      push_frame(i_digits);
      collect_frame(1'b1, 1'b0, '0);
   endtask

   task automatic test_mid_change;
      logic [59:0] a, b;
      a = pack(48'h123456789012);
      b = pack(48'h987654321098);
      i_digits = a;
      push_frame(a);
      collect_frame(1'b1, 1'b1, b);
      push_frame(b);
      collect_frame(1'b1, 1'b0, '0);
   endtask

   task automatic test_hold;
      logic [59:0] b, c;
      b = pack(48'h987654321098);
      c = pack(48'h555555555555);
      i_digits = c;
      i_hold   = 1'b1;
      push_frame(b);
      collect_frame(1'b1, 1'b0, '0);
      i_hold = 1'b0;
      push_frame(c);
      collect_frame(1'b1, 1'b0, '0);
   endtask

   task automatic test_reset_mid;
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_frame && n < 4 * FRAME);
      repeat (3) @(negedge i_clk);
      #1 i_rst = 1'b1;
      #1;
      total_cnt++;
      if (o_seg !== 7'h00 || o_dig !== 4'hF || o_frame !== 1'b0 || o_err !== 1'b0)
         $display("FAIL reset_mid: got seg=%h dig=%h frame=%b err=%b, need 00 F 0 0", o_seg, o_dig, o_frame, o_err);
      else
         pass_cnt++;
      @(negedge i_clk);
      #1 i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      total_cnt++;
      if (o_frame !== 1'b0 || o_dig !== 4'hF)
         $display("FAIL post_rst_edge1: got frame=%b dig=%h, need 0 F", o_frame, o_dig);
      else
         pass_cnt++;
      @(posedge i_clk);
      #1;
      total_cnt++;
      if (o_frame !== 1'b1 || o_dig !== 4'd11 || o_seg !== 7'h6D)
         $display("FAIL post_rst_edge2: got frame=%b dig=%h seg=%h, need 1 B 6D", o_frame, o_dig, o_seg);
      else
         pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_frame_period();
      test_counting();
      test_embedded_zeros();
      test_invalid();
      test_mid_change();
      test_hold();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
